// File: rtl/bram_stream_reader.sv
// Ring-buffer drain: reads BRAM port B behind a free-running write pointer and
// presents the words as an AXI4-Stream master with frame tlast and sticky overrun.
module bram_stream_reader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16384,
  parameter int FRAME_WORDS = 128,
  localparam int PTR_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [PTR_W-1:0]      wr_ptr,
  output logic                  portb_en,
  output logic [3:0]            portb_we,
  output logic [ADDR_WIDTH-1:0] portb_addr,
  output logic [DATA_WIDTH-1:0] portb_din,
  input  logic [DATA_WIDTH-1:0] portb_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [PTR_W-1:0]      rd_ptr,
  output logic [PTR_W-1:0]      fill_level,
  output logic                  overflow
);

  localparam int FC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t [1:0]    fifo;
  logic            wr_idx, rd_idx;
  logic [1:0]      count;
  logic            in_flight, flight_last;
  logic [FC_W-1:0] frame_cnt;
  logic            pop, issue, frame_end;
  logic [2:0]      occupancy;

  assign fill_level    = wr_ptr - rd_ptr;
  assign m_axis_tvalid = (count != 2'd0);
  assign m_axis_tdata  = fifo[rd_idx].data;
  assign m_axis_tlast  = fifo[rd_idx].last;
  assign pop           = m_axis_tvalid && m_axis_tready;

  // A pop this cycle frees its slot for a read issued this cycle, which keeps
  // one word per cycle flowing while never holding more than two words.
  assign occupancy = {2'b00, in_flight} + {1'b0, count} - {2'b00, pop};
  assign issue     = !rst && enable && !overflow && (fill_level != '0) && (occupancy < 3'd2);
  assign frame_end = (frame_cnt == FC_W'(FRAME_WORDS - 1));

  assign portb_en   = issue;
  assign portb_we   = 4'b0000;
  assign portb_din  = '0;
  assign portb_addr = ADDR_WIDTH'({rd_ptr[PTR_W-2:0], 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      frame_cnt   <= '0;
      in_flight   <= 1'b0;
      flight_last <= 1'b0;
      fifo        <= '0;
      wr_idx      <= 1'b0;
      rd_idx      <= 1'b0;
      count       <= 2'd0;
      overflow    <= 1'b0;
    end else begin
      if (fill_level > PTR_W'(DEPTH)) overflow <= 1'b1;
      in_flight <= issue;
      if (issue) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        flight_last <= frame_end;
        frame_cnt   <= frame_end ? '0 : frame_cnt + FC_W'(1);
      end
      // The tlast tag rides with the read so it lands on the returned word.
      if (in_flight) begin
        fifo[wr_idx].data <= portb_dout;
        fifo[wr_idx].last <= flight_last;
        wr_idx            <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      count <= count + {1'b0, in_flight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: BRAM read model, stream monitor and
// immediate-assertion checks over reset, streaming, stalls, wrap, framing, overrun.
module tb_bram_stream_reader;

  localparam int PTR_W = 15;

  logic              clk, rst, enable;
  logic [PTR_W-1:0]  wr_ptr;
  logic              portb_en;
  logic [3:0]        portb_we;
  logic [15:0]       portb_addr;
  logic [31:0]       portb_din, portb_dout;
  logic [31:0]       m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [PTR_W-1:0]  rd_ptr, fill_level;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  bram_stream_reader #(.FRAME_WORDS(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_ptr(wr_ptr),
    .portb_en(portb_en), .portb_we(portb_we), .portb_addr(portb_addr),
    .portb_din(portb_din), .portb_dout(portb_dout),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .rd_ptr(rd_ptr), .fill_level(fill_level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM stand-in: word at index i holds C0DE in the top half and i below.
  always @(posedge clk)
    if (portb_en) portb_dout <= {16'hC0DE, 2'b00, portb_addr[15:2]};

  function automatic logic [31:0] w(input int i);
    return {16'hC0DE, 2'b00, i[13:0]};
  endfunction

  // Stream monitor: logs every handshake, tracks words held, and stall stability.
  logic [31:0] got_d[$];
  logic        got_l[$];
  int          n_iss, n_pop, held_max = 0, stall_bad = 0, stall_cnt = 0;
  logic        stall_prev;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    if (rst) begin
      n_iss = 0; n_pop = 0; stall_prev = 1'b0;
    end else begin
      if (n_iss - n_pop > held_max) held_max = n_iss - n_pop;
      if (stall_prev && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
        stall_bad++;
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
        n_pop++;
      end
      if (portb_en) n_iss++;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      if (stall_prev) stall_cnt++;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int   base;
  logic en_seen;

  initial begin
    rst = 1'b1; enable = 1'b1; wr_ptr = 5; m_axis_tready = 1'b1;

    // reset held with data pending
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_en", portb_en, 0);
      chk("rst_rdptr", rd_ptr, 0);
      chk("rst_ovf", overflow, 0);
    end
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_addr", portb_addr, 0);

    // basic stream of 4 words
    wr_ptr = 0; cyc();
    rst = 1'b0; wr_ptr = 4; #1;
    chk("b0_en", portb_en, 1); chk("b0_addr", portb_addr, 16'h0); chk("b0_vld", m_axis_tvalid, 0);
    cyc(); #1;
    chk("b1_en", portb_en, 1); chk("b1_addr", portb_addr, 16'h4); chk("b1_vld", m_axis_tvalid, 0);
    cyc(); #1;
    chk("b2_addr", portb_addr, 16'h8); chk("b2_vld", m_axis_tvalid, 1); chk("b2_data", m_axis_tdata, w(0));
    cyc(); #1;
    chk("b3_addr", portb_addr, 16'hC); chk("b3_data", m_axis_tdata, w(1)); chk("b3_last", m_axis_tlast, 0);
    cyc(); #1;
    chk("b4_en", portb_en, 0); chk("b4_data", m_axis_tdata, w(2));
    chk("b4_rdptr", rd_ptr, 4); chk("b4_fill", fill_level, 0);
    cyc(); #1;
    chk("b5_vld", m_axis_tvalid, 1); chk("b5_data", m_axis_tdata, w(3)); chk("b5_last", m_axis_tlast, 1);
    cyc(); #1;
    chk("b6_vld", m_axis_tvalid, 0);

    // backpressure: 10 words, 5 stalled cycles then alternating ready
    m_axis_tready = 1'b0; wr_ptr = 14; base = got_d.size(); #1;
    chk("bp0_addr", portb_addr, 16'h10);
    for (int i = 0; i < 4; i++) cyc();
    #1;
    chk("bp4_vld", m_axis_tvalid, 1); chk("bp4_data", m_axis_tdata, w(4)); chk("bp4_en", portb_en, 0);
    for (int i = 0; i < 80 && got_d.size() < base + 10; i++) begin
      cyc(); m_axis_tready = ~m_axis_tready;
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    #1;
    chk("bp_count", got_d.size() - base, 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp_data%0d", k), got_d[base+k], w(4 + k));
      chk($sformatf("bp_last%0d", k), got_l[base+k], (k == 3 || k == 7));
    end
    chk("bp_held_max", held_max <= 2, 1);
    chk("bp_stall_stable", stall_bad, 0);
    chk("bp_stalls_seen", stall_cnt > 4, 1);
    chk("bp_rdptr", rd_ptr, 14);

    // address wrap around the ring end
    rst = 1'b1; wr_ptr = 0; cyc(); cyc();
    rst = 1'b0; wr_ptr = 16382;
    for (int i = 0; i < 17000; i++) begin
      cyc();
      if (rd_ptr == 16382 && !m_axis_tvalid) break;
    end
    #1;
    chk("wr_pre_rdptr", rd_ptr, 16382); chk("wr_pre_vld", m_axis_tvalid, 0);
    wr_ptr = 16386; base = got_d.size(); #1;
    chk("wr0_addr", portb_addr, 16'hFFF8);
    cyc(); #1; chk("wr1_addr", portb_addr, 16'hFFFC);
    cyc(); #1; chk("wr2_addr", portb_addr, 16'h0000); chk("wr2_en", portb_en, 1);
    cyc(); #1; chk("wr3_addr", portb_addr, 16'h0004);
    cyc(); #1; chk("wr4_en", portb_en, 0); chk("wr4_rdptr", rd_ptr, 16386);
    for (int i = 0; i < 3; i++) cyc();
    #1;
    chk("wr_count", got_d.size() - base, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("wr_data%0d", k), got_d[base+k], w(16382 + k));
    chk("wr_fill", fill_level, 0);

    // framing with an enable gap after word 5
    rst = 1'b1; wr_ptr = 0; cyc(); cyc();
    rst = 1'b0; wr_ptr = 10; base = got_d.size(); #1;
    chk("fr0_addr", portb_addr, 16'h0);
    for (int i = 0; i < 5; i++) cyc();
    #1;
    chk("fr5_en", portb_en, 1); chk("fr5_addr", portb_addr, 16'h14);
    cyc(); enable = 1'b0; #1;
    chk("fr_off_en", portb_en, 0); chk("fr_off_rdptr", rd_ptr, 6);
    for (int i = 0; i < 20; i++) cyc();
    #1;
    chk("fr_hold_rdptr", rd_ptr, 6); chk("fr_hold_vld", m_axis_tvalid, 0);
    chk("fr_hold_count", got_d.size() - base, 6);
    enable = 1'b1; #1;
    chk("fr_on_en", portb_en, 1); chk("fr_on_addr", portb_addr, 16'h18);
    for (int i = 0; i < 40 && got_d.size() < base + 10; i++) cyc();
    for (int i = 0; i < 3; i++) cyc();
    #1;
    chk("fr_count", got_d.size() - base, 10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("fr_data%0d", k), got_d[base+k], w(k));
      chk($sformatf("fr_last%0d", k), got_l[base+k], (k == 3 || k == 7));
    end

    // overrun with two words buffered
    m_axis_tready = 1'b0; wr_ptr = 12;
    for (int i = 0; i < 4; i++) cyc();
    #1;
    chk("ov_pre_vld", m_axis_tvalid, 1); chk("ov_pre_data", m_axis_tdata, w(10));
    chk("ov_pre_rdptr", rd_ptr, 12);
    cyc(); wr_ptr = 16397; #1;
    chk("ov_fill", fill_level, 16385); chk("ov_same_cyc", overflow, 0); chk("ov_same_en", portb_en, 0);
    cyc(); #1;
    chk("ov_set", overflow, 1); chk("ov_set_en", portb_en, 0);
    base = got_d.size(); m_axis_tready = 1'b1; en_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i == 5) wr_ptr = 15;
      #1;
      en_seen |= portb_en;
    end
    chk("ov_no_issue", en_seen, 0);
    chk("ov_drain_count", got_d.size() - base, 2);
    chk("ov_drain_d0", got_d[base], w(10)); chk("ov_drain_l0", got_l[base], 0);
    chk("ov_drain_d1", got_d[base+1], w(11)); chk("ov_drain_l1", got_l[base+1], 1);
    chk("ov_sticky", overflow, 1); chk("ov_rdptr", rd_ptr, 12);
    rst = 1'b1; cyc(); #1;
    chk("ov_rst_flag", overflow, 0); chk("ov_rst_rdptr", rd_ptr, 0);
    chk("ov_rst_vld", m_axis_tvalid, 0); chk("ov_rst_en", portb_en, 0);

    chk("all_stall_stable", stall_bad, 0);
    chk("all_held_max", held_max <= 2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
